bram_burst_ctrl: RTL and testbench

Parametrised BRAM burst controller serving one requester through a valid/ready request channel. Issues pipelined reads at one word per cycle into an internal output FIFO, and supports streamed burst writes. Adds configurable BRAM read latency, credit-based backpressure, abort, and a completion pulse. Sits between the channel-processing logic and a single-port BRAM.

---
 rtl/dataTypes_pkg.sv | 16 +
 rtl/burst_fifo.sv | 59 +++++
 rtl/bram_burst_ctrl.sv | 147 ++++++++++++++
 tb/tb_bram_burst_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataTypes_pkg.sv
// rtl/dataTypes_pkg.sv - shared types and helpers for the BRAM burst controller
package dataTypes_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE
  } bram_burst_state_t;

  // Occupancy counter width: must hold the value DEPTH itself, hence the +1.
  function automatic int BURST_FIFO_CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/burst_fifo.sv
// rtl/burst_fifo.sv - show-ahead synchronous FIFO holding returned read words
module burst_fifo
  import dataTypes_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int CNT_W = BURST_FIFO_CNT_W(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Push while full is allowed when a pop frees the slot in the same cycle.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || pop);
    dout    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at once.
  always_ff @(posedge clk) begin
    if (!resetN || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bram_burst_ctrl.sv
// rtl/bram_burst_ctrl.sv - burst read/write controller in front of a single-port BRAM
module bram_burst_ctrl
  import dataTypes_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              bram_en,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam int CNT_W = BURST_FIFO_CNT_W(FIFO_DEPTH);

  if (READ_LAT < 1) begin : g_bad_lat
    $error("bram_burst_ctrl: READ_LAT must be at least 1");
  end
  if ((FIFO_DEPTH < READ_LAT + 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("bram_burst_ctrl: FIFO_DEPTH must be a power of two and >= READ_LAT+2");
  end

  bram_burst_state_t state;
  bram_burst_state_t state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic [READ_LAT-1:0] vld;
  logic              done_q;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              credit_ok;
  logic              accept;
  logic              issue;
  logic              beat;

  burst_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .flush  (abort),
    .push   (vld[READ_LAT-1]),
    .din    (bram_rdata),
    .pop    (rd_ready),
    .dout   (rd_data),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  assign rd_valid = !fifo_empty;

  // Reads in flight = number of set bits in the latency shift register.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + CNT_W'(vld[i]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; abort always returns to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && (req_len != '0)) state_nxt = req_write ? S_WRITE : S_READ;
      S_READ:  if (issue && (remaining == LEN_W'(1))) state_nxt = S_DRAIN;
      S_DRAIN: if (inflight == '0) state_nxt = S_IDLE;
      S_WRITE: if (beat && (remaining == LEN_W'(1))) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Outputs and handshakes; reserved FIFO slots include words still in the BRAM pipe.
  always_comb begin
    credit_ok  = !fifo_full &&
                 (({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH));
    req_ready  = resetN && (state == S_IDLE);
    accept     = req_ready && req_valid && !abort;
    issue      = resetN && (state == S_READ) && (remaining != '0) && credit_ok && !abort;
    wr_ready   = resetN && (state == S_WRITE);
    beat       = wr_ready && wr_valid && !abort;
    bram_en    = issue || beat;
    bram_we    = beat;
    bram_addr  = cur_addr;
    bram_wdata = wr_data;
    busy       = resetN && (state != S_IDLE);
    done       = resetN && (done_q || ((state == S_DRAIN) && (inflight == '0) && !abort));
  end

  // Address/length counters, latency pipe and the delayed completion for writes and empty bursts.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cur_addr  <= '0;
      remaining <= '0;
      vld       <= '0;
      done_q    <= 1'b0;
    end else if (abort) begin
      remaining <= '0;
      vld       <= '0;
      done_q    <= 1'b0;
    end else begin
      vld[0] <= issue;
      for (int i = 1; i < READ_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
      done_q <= (accept && (req_len == '0)) || (beat && (remaining == LEN_W'(1)));
      if (accept) begin
        cur_addr  <= req_addr;
        remaining <= req_len;
      end else if (issue || beat) begin
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// tb/tb_bram_burst_ctrl.sv - self-checking bench for bram_burst_ctrl
module tb_bram_burst_ctrl;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 32;
  localparam int LEN_W      = 16;
  localparam int READ_LAT   = 2;
  localparam int FIFO_DEPTH = 16;

  logic              clk;
  logic              resetN;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              abort;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              bram_en;
  logic              bram_we;
  logic [DATA_W-1:0] bram_rdata;

  int checks = 0;
  int errors = 0;

  bram_burst_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .READ_LAT   (READ_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .abort      (abort),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .done       (done),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_rdata (bram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: unwritten words read back as their own address.
  logic [DATA_W-1:0] bmem [int];
  logic [DATA_W-1:0] rpipe [READ_LAT];
  always @(posedge clk) begin
    rpipe[0] <= bmem.exists(int'(bram_addr)) ? bmem[int'(bram_addr)] : DATA_W'(bram_addr);
    for (int i = 1; i < READ_LAT; i++) rpipe[i] <= rpipe[i-1];
    if (bram_en && bram_we) bmem[int'(bram_addr)] = bram_wdata;
  end
  assign bram_rdata = rpipe[READ_LAT-1];

  // Reference memory contents, updated from the burst-level view of each write.
  logic [DATA_W-1:0] ref_mem [int];
  function automatic int wrap(input int a);
    return a & ((1 << ADDR_W) - 1);
  endfunction
  function automatic logic [DATA_W-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : DATA_W'(a);
  endfunction

  // Cycle index and per-operation statistics, sampled just before each rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int en_cnt, bad_en, done_cnt, done_cyc, first_rv, first_pop, last_pop;
  logic [DATA_W-1:0] got_q [$];
  always @(negedge clk) begin
    #4;
    if (resetN) begin
      if (bram_en) en_cnt++;
      if (bram_en && (!bram_we || !wr_valid)) bad_en++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (rd_valid && first_rv < 0) first_rv = cyc;
      if (rd_valid && rd_ready) begin
        got_q.push_back(rd_data);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  task automatic clear_stats();
    en_cnt = 0; bad_en = 0; done_cnt = 0; done_cyc = -1;
    first_rv = -1; first_pop = -1; last_pop = -1;
    got_q.delete();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request; returns at the falling edge inside the cycle after acceptance.
  task automatic request(input bit w, input int a, input int l, output int c0);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = ADDR_W'(a); req_len = LEN_W'(l);
    #2;
    check("req_ready_at_accept", req_ready, 1);
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_read(input string tag, input int a, input int l, input int hold,
                          input int ready_pct, output int c0);
    int n;
    clear_stats();
    request(1'b0, a, l, c0);
    for (n = 0; n < 3000; n++) begin
      rd_ready = (n < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
      #2;
      if (hold > 0 && n == hold) begin
        check({tag, "_stall_issues"}, en_cnt, FIFO_DEPTH);
        check({tag, "_stall_nopop"}, got_q.size(), 0);
      end
      if (done_cnt > 0 && rd_valid !== 1'b1) break;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    check({tag, "_no_timeout"}, n < 3000, 1);
    check({tag, "_word_count"}, got_q.size(), l);
    check({tag, "_issue_count"}, en_cnt, l);
    check({tag, "_done_count"}, done_cnt, 1);
    for (int i = 0; i < l && i < got_q.size(); i++)
      check({tag, "_data"}, got_q[i], ref_rd(wrap(a + i)));
  endtask

  // mode 0: wr_valid held high, 1: alternating starting high, 2: random
  task automatic run_write(input string tag, input int a, input int l, input int mode);
    logic [DATA_W-1:0] d [$];
    int c0, n, idx, last_beat;
    for (int i = 0; i < l; i++) d.push_back($urandom);
    clear_stats();
    request(1'b1, a, l, c0);
    idx = 0; last_beat = -1;
    for (n = 0; n < 500 && idx < l; n++) begin
      wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(1));
      wr_data  = wr_valid ? d[idx] : 32'hDEAD_BEEF;
      #2;
      if (wr_valid && wr_ready) begin idx++; last_beat = cyc; end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check({tag, "_no_timeout"}, idx, l);
    check({tag, "_en_count"}, en_cnt, l);
    check({tag, "_en_only_on_beats"}, bad_en, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_cyc, last_beat + 1);
    for (int i = 0; i < l; i++) begin
      check({tag, "_mem"}, bmem.exists(wrap(a + i)) ? bmem[wrap(a + i)] : 'x, d[i]);
      ref_mem[wrap(a + i)] = d[i];
    end
  endtask

  initial begin
    int c0, a, l;
    resetN = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    abort = 1'b0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    clear_stats();

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_wr_ready", wr_ready, 0);
    resetN = 1'b1;
    @(negedge clk);
    #2;
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rd_valid", rd_valid, 0);
    check("post_rst_busy", busy, 0);

    // Basic read: latency, throughput and completion timing
    run_read("rd8", 'h10, 8, 0, 100, c0);
    check("rd8_first_rv", first_rv, c0 + 2 + READ_LAT);
    check("rd8_done_cycle", done_cyc, c0 + 1 + 8 + READ_LAT);
    check("rd8_back_to_back", last_pop - first_pop, 7);
    check("rd8_first_word", got_q.size() > 0 ? got_q[0] : 'x, 32'h10);

    // Backpressure: issue must stop at FIFO_DEPTH with consumer stalled
    run_read("bp40", 'h200, 40, 30, 100, c0);

    // Write across the top of the address space
    run_write("wr_wrap", 'h7FFE, 4, 0);
    check("wr_wrap_neighbour_untouched", bmem.exists('h7FFD), 0);
    run_read("rd_wrap", 'h7FFD, 5, 0, 100, c0);

    // Gapped write beats
    run_write("wr_gap", 'h40, 3, 1);

    // Abort with five words sitting in the FIFO
    clear_stats();
    rd_ready = 1'b0;
    request(1'b0, 'h100, 20, c0);
    for (int k = 0; k < 20 && cyc < c0 + 2 + READ_LAT + 4; k++) @(negedge clk);
    abort = 1'b1;
    #2;
    check("abort_pre_issues", en_cnt, 7);
    check("abort_pre_rd_valid", rd_valid, 1);
    check("abort_cycle_bram_en", bram_en, 0);
    @(negedge clk);
    abort = 1'b0;
    #2;
    check("abort_rd_valid", rd_valid, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_pop", got_q.size(), 0);
    run_read("rd_after_abort", 'h300, 6, 0, 100, c0);

    // Request presented together with abort is ignored
    clear_stats();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 'h50; req_len = 4; abort = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; abort = 1'b0;
    #2;
    check("abort_req_busy", busy, 0);
    repeat (4) @(negedge clk);
    check("abort_req_no_issue", en_cnt, 0);
    check("abort_req_no_done", done_cnt, 0);

    // Zero-length request
    clear_stats();
    request(1'b0, 'h20, 0, c0);
    repeat (3) @(negedge clk);
    #2;
    check("len0_no_bram", en_cnt, 0);
    check("len0_done_count", done_cnt, 1);
    check("len0_done_cycle", done_cyc, c0 + 1);

    // Random mix around the wrap point so reads observe earlier writes
    for (int k = 0; k < 10; k++) begin
      a = wrap('h7FF0 + $urandom_range(31));
      if ($urandom_range(1) == 1) begin
        l = $urandom_range(1, 12);
        run_write("rnd_wr", a, l, $urandom_range(2));
      end else begin
        l = $urandom_range(1, 24);
        run_read("rnd_rd", a, l, 0, $urandom_range(30, 100), c0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
